i2c_slave: RTL

- I2C target (slave) that responds to the team's i2c_master over the same two-wire bus, e.g. as the downstream-facing end of the address translator.
- Oversamples scl/sda on the system clock, detects START/STOP, matches a 7-bit address and receives or transmits byte streams.
- Drives sda open-drain only: low or released, never high.

---
 rtl/i2c_slave.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// i2c_slave - I2C target with 7-bit address match, byte-stream write and read.
//
// Oversamples scl/sda on clk, detects START/STOP, matches own_addr and then
// either receives bytes (ACKing each) or returns bytes supplied on tx_data.
// sda is only ever pulled low or released.
//
// Ports
//    clk       system clock, at least 16x the scl frequency
//    arst      asynchronous active-high reset
//    own_addr  7-bit device address, sampled at each address compare
//    tx_data   byte returned on reads, loaded at the fall that starts a byte
//    scl       bus clock from the master
//    sda       bus data, driven 0 or z
//    rx_data   last byte written by the master
//    rx_valid  one-clk pulse when rx_data updates
//    rd_req    one-clk pulse asking for the next tx_data
//    busy      high whenever the FSM is not IDLE
//
// state     | meaning
// IDLE      | bus idle or not addressed, waiting for START
// ADDR      | shifting in address + R/W bit; holds ACK pending until scl fall
// ADDR_ACK  | driving address ACK low
// WR_DATA   | shifting in a write byte; holds ACK pending until scl fall
// WR_ACK    | driving data ACK low
// RD_DATA   | presenting a read byte MSB first
// RD_ACK    | sda released, sampling master ACK/NACK
// WAIT_STOP | not addressed or read ended by NACK; waits for START/STOP

module i2c_slave #(
   parameter int SYNC_STAGES = 2   // must be >= 2
) (
   input  logic       clk,
   input  logic       arst,
   input  logic [6:0] own_addr,
   input  logic [7:0] tx_data,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rd_req,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      WR_DATA   = 3'd3,
      WR_ACK    = 3'd4,
      RD_DATA   = 3'd5,
      RD_ACK    = 3'd6,
      WAIT_STOP = 3'd7
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rd_req_q, rd_req_d;
   logic       pend_q, pend_d;      // byte finished, action waits for next scl fall
   logic       rw_q, rw_d;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic       scl_prev_q, sda_prev_q;
   logic       scl_s, sda_s;
   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] shift_in;

   // Release is combinational on arst so the bus frees in the same clk.
   assign sda = (sda_oe_q && !arst) ? 1'b0 : 1'bz;

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  =  scl_s && !scl_prev_q;
   assign scl_fall  = !scl_s &&  scl_prev_q;
   assign start_det =  scl_s &&  scl_prev_q &&  sda_prev_q && !sda_s;
   assign stop_det  =  scl_s &&  scl_prev_q && !sda_prev_q &&  sda_s;
   assign shift_in  = {shift_q[6:0], sda_s};

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rd_req   = rd_req_q;
   assign busy     = (state_q != IDLE);

   // Synchronizers reset to 1 (idle bus) so leaving reset never fakes an edge.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         rd_req_q   <= 1'b0;
         pend_q     <= 1'b0;
         rw_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rd_req_q   <= rd_req_d;
         pend_q     <= pend_d;
         rw_q       <= rw_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rd_req_d   = 1'b0;
      pend_d     = pend_q;
      rw_d       = rw_q;

      if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = 3'd7;
         sda_oe_d  = 1'b0;
         pend_d    = 1'b0;
      end else if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = 3'd0;
         sda_oe_d  = 1'b0;
         pend_d    = 1'b0;
      end else begin
         case (state_q)
            ADDR: begin
               if (scl_rise && !pend_q) begin
                  shift_d = shift_in;
                  if (bit_cnt_q == 3'd0) begin
                     if (shift_in[7:1] == own_addr) begin
                        pend_d   = 1'b1;
                        rw_d     = shift_in[0];
                        rd_req_d = shift_in[0];
                     end else begin
                        state_d = WAIT_STOP;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end else if (scl_fall && pend_q) begin
                  pend_d   = 1'b0;
                  sda_oe_d = 1'b1;
                  state_d  = ADDR_ACK;
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = 3'd7;
                  if (rw_q) begin
                     shift_d  = tx_data;
                     sda_oe_d = ~tx_data[7];
                     state_d  = RD_DATA;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = WR_DATA;
                  end
               end
            end
            WR_DATA: begin
               if (scl_rise && !pend_q) begin
                  shift_d = shift_in;
                  if (bit_cnt_q == 3'd0) begin
                     rx_data_d  = shift_in;
                     rx_valid_d = 1'b1;
                     pend_d     = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end else if (scl_fall && pend_q) begin
                  pend_d   = 1'b0;
                  sda_oe_d = 1'b1;
                  state_d  = WR_ACK;
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 3'd7;
                  state_d   = WR_DATA;
               end
            end
            RD_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     sda_oe_d = 1'b0;
                     state_d  = RD_ACK;
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                     shift_d   = {shift_q[6:0], 1'b1};
                     sda_oe_d  = ~shift_q[6];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise && !pend_q) begin
                  if (!sda_s) begin
                     rd_req_d = 1'b1;
                     pend_d   = 1'b1;
                  end else begin
                     state_d = WAIT_STOP;
                  end
               end else if (scl_fall && pend_q) begin
                  pend_d    = 1'b0;
                  shift_d   = tx_data;
                  sda_oe_d  = ~tx_data[7];
                  bit_cnt_d = 3'd7;
                  state_d   = RD_DATA;
               end
            end
            default: ;   // IDLE and WAIT_STOP only leave on START/STOP
         endcase
      end
   end

endmodule
